// File: rtl/seven_seg_scan_if.sv
// Bus bundle for the seven-segment scanner: value/strobe inputs and display outputs.
// The host drives through "master"; the scanner binds to "slave".
interface seven_seg_scan_if #(
    parameter int NDIGITS = 4
);
    logic                   enable;
    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [NDIGITS-1:0]     dp_in;
    logic                   blank_lz;
    logic                   pending;
    logic                   frame_tick;
    logic [6:0]             seg;
    logic                   dp;
    logic [NDIGITS-1:0]     an;

    modport master (
        output enable, load, value, dp_in, blank_lz,
        input  pending, frame_tick, seg, dp, an
    );

    modport slave (
        input  enable, load, value, dp_in, blank_lz,
        output pending, frame_tick, seg, dp, an
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment driver with a shadow buffer that is only copied into
// the displayed value at frame boundaries, so a digit update never tears mid-frame.
module seven_seg_scan #(
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 1000,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit AN_ACT_LOW  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    seven_seg_scan_if.slave bus
);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IW-1:0]      IDX_LAST = IW'(NDIGITS - 1);
    localparam logic [DW-1:0]      DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [6:0]         SEG_OFF  = {7{SEG_ACT_LOW}};
    localparam logic               DP_OFF   = SEG_ACT_LOW;
    localparam logic [NDIGITS-1:0] AN_OFF   = {NDIGITS{AN_ACT_LOW}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        hex_to_seg = 7'h00;
        case (nib)
            4'h0: hex_to_seg = 7'h7E;
            4'h1: hex_to_seg = 7'h30;
            4'h2: hex_to_seg = 7'h6D;
            4'h3: hex_to_seg = 7'h79;
            4'h4: hex_to_seg = 7'h33;
            4'h5: hex_to_seg = 7'h5B;
            4'h6: hex_to_seg = 7'h5F;
            4'h7: hex_to_seg = 7'h70;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h7B;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h1F;
            4'hC: hex_to_seg = 7'h4E;
            4'hD: hex_to_seg = 7'h3D;
            4'hE: hex_to_seg = 7'h4F;
            4'hF: hex_to_seg = 7'h47;
        endcase
    endfunction

    logic [DW-1:0]          div_q, div_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*NDIGITS-1:0]   shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
    logic [NDIGITS-1:0]     shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic                   pending_q, pending_d;
    logic                   frame_tick_q, frame_tick_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [NDIGITS-1:0]     an_q, an_d;

    logic                   boundary;
    logic [3:0]             nib [NDIGITS];
    logic [NDIGITS-1:0]     lz;
    logic [NDIGITS-1:0]     an_raw;
    logic [6:0]             seg_raw;

    // lz[i]: every displayed nibble from the leftmost digit down to digit i is zero
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
        assign nib[gi]    = disp_val_q[4*gi +: 4];
        assign lz[gi]     = (disp_val_q[4*NDIGITS-1 : 4*gi] == '0);
        assign an_raw[gi] = (idx_q == IW'(gi));
    end

    always_comb begin
        div_d    = div_q;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (bus.enable) begin
            if (div_q == DIV_LAST) begin
                div_d    = '0;
                boundary = (idx_q == IDX_LAST);
                idx_d    = boundary ? '0 : idx_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // A load landing on the boundary cycle goes straight to the display.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;
        frame_tick_d = boundary;
        if (boundary) begin
            pending_d = 1'b0;
            if (bus.load) begin
                disp_val_d = bus.value;
                disp_dp_d  = bus.dp_in;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
            end
        end else if (bus.load) begin
            shadow_val_d = bus.value;
            shadow_dp_d  = bus.dp_in;
            pending_d    = 1'b1;
        end
    end

    always_comb begin
        seg_raw = hex_to_seg(nib[idx_q]);
        if (bus.blank_lz && (idx_q != '0) && lz[idx_q]) begin
            seg_raw = 7'h00;
        end
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (bus.enable) begin
            seg_d = seg_raw ^ SEG_OFF;
            dp_d  = disp_dp_q[idx_q] ^ DP_OFF;
            an_d  = an_raw ^ AN_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Checks two scanner instances (active-high and active-low outputs) against a
// model that derives digit position from a running count of enabled cycles.
module tb_seven_seg_scan;
    localparam int N = 4;
    localparam int R = 4;
    localparam int FRAME = N * R;
    localparam logic [6:0] SEGTAB [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_if #(.NDIGITS(N)) if_p ();
    seven_seg_scan_if #(.NDIGITS(N)) if_n ();

    assign if_n.enable   = if_p.enable;
    assign if_n.load     = if_p.load;
    assign if_n.value    = if_p.value;
    assign if_n.dp_in    = if_p.dp_in;
    assign if_n.blank_lz = if_p.blank_lz;

    seven_seg_scan #(.NDIGITS(N), .REFRESH_DIV(R), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0))
        u_dut_p (.clk(clk), .rst_n(rst_n), .bus(if_p.slave));
    seven_seg_scan #(.NDIGITS(N), .REFRESH_DIV(R), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1))
        u_dut_n (.clk(clk), .rst_n(rst_n), .bus(if_n.slave));

    int compared = 0;
    int mismatched = 0;

    // Model state: t = enabled cycles since reset; digit = (t/R) mod N.
    int         t;
    logic [15:0] m_disp, m_sh;
    logic [3:0]  m_dpd, m_dps;
    logic        m_pend;
    logic [6:0]  e_seg;
    logic        e_dp, e_ft;
    logic [3:0]  e_an;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0; m_disp = '0; m_sh = '0; m_dpd = '0; m_dps = '0; m_pend = 1'b0;
        e_seg = '0; e_dp = 1'b0; e_ft = 1'b0; e_an = '0;
    endtask

    task automatic model_edge();
        int d;
        bit bnd;
        d   = (t / R) % N;
        bnd = if_p.enable && ((t % FRAME) == FRAME - 1);
        if (if_p.enable) begin
            e_an = 4'(1 << d);
            e_dp = m_dpd[d];
            if (if_p.blank_lz && d > 0 && (m_disp >> (4 * d)) == 16'h0) e_seg = 7'h00;
            else e_seg = SEGTAB[m_disp[4*d +: 4]];
        end else begin
            e_an = '0; e_dp = 1'b0; e_seg = '0;
        end
        e_ft = bnd;
        if (bnd) begin
            if (if_p.load) begin
                m_disp = if_p.value; m_dpd = if_p.dp_in;
            end else if (m_pend) begin
                m_disp = m_sh; m_dpd = m_dps;
            end
            m_pend = 1'b0;
        end else if (if_p.load) begin
            m_sh = if_p.value; m_dps = if_p.dp_in; m_pend = 1'b1;
        end
        if (if_p.enable) t++;
    endtask

    task automatic check_all();
        logic [6:0] nseg;
        logic       ndp;
        logic [3:0] nan;
        nseg = ~e_seg; ndp = ~e_dp; nan = ~e_an;
        chk("seg", 16'(if_p.seg), 16'(e_seg));
        chk("dp", 16'(if_p.dp), 16'(e_dp));
        chk("an", 16'(if_p.an), 16'(e_an));
        chk("pending", 16'(if_p.pending), 16'(m_pend));
        chk("frame_tick", 16'(if_p.frame_tick), 16'(e_ft));
        chk("seg_actlow", 16'(if_n.seg), 16'(nseg));
        chk("dp_actlow", 16'(if_n.dp), 16'(ndp));
        chk("an_actlow", 16'(if_n.an), 16'(nan));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        $display("t=%0d en=%0b ld=%0b an=%b seg=%h dp=%0b pend=%0b ft=%0b", t, if_p.enable,
                 if_p.load, if_p.an, if_p.seg, if_p.dp, if_p.pending, if_p.frame_tick);
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        if_p.load = 1'b1; if_p.value = v; if_p.dp_in = d;
        step();
        if_p.load = 1'b0;
    endtask

    task automatic wait_frame();
        logic seen;
        seen = if_p.frame_tick;
        for (int k = 0; k < 3 * FRAME && !seen; k++) begin
            step();
            seen = if_p.frame_tick;
        end
        chk("frame_tick_seen", 16'(seen), 16'h1);
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < 3 * FRAME && (t % FRAME) != ph; k++) step();
        chk("phase_reached", 16'(t % FRAME), 16'(ph));
    endtask

    initial begin
        if_p.enable = 1'b0; if_p.load = 1'b0; if_p.value = '0;
        if_p.dp_in = '0; if_p.blank_lz = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_seg_n", 16'(if_n.seg), 16'h7F);
        chk("rst_an_n", 16'(if_n.an), 16'hF);
        rst_n = 1'b1;
        if_p.enable = 1'b1;
        step_n(2);

        // Load 1234, then walk the four digits
        do_load(16'h1234, 4'h0);
        chk("t1_pending", 16'(if_p.pending), 16'h1);
        wait_frame();
        step();    chk("t1_an0", 16'(if_p.an), 16'h1); chk("t1_seg0", 16'(if_p.seg), 16'h33);
        step_n(4); chk("t1_an1", 16'(if_p.an), 16'h2); chk("t1_seg1", 16'(if_p.seg), 16'h79);
        step_n(4); chk("t1_an2", 16'(if_p.an), 16'h4); chk("t1_seg2", 16'(if_p.seg), 16'h6D);
        step_n(4); chk("t1_an3", 16'(if_p.an), 16'h8); chk("t1_seg3", 16'(if_p.seg), 16'h30);

        // Leading-zero blanking
        if_p.blank_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        wait_frame();
        step();    chk("t2_seg0", 16'(if_p.seg), 16'h7E);
        step_n(4); chk("t2_seg1", 16'(if_p.seg), 16'h5B);
        step_n(4); chk("t2_seg2", 16'(if_p.seg), 16'h00); chk("t2_an2", 16'(if_p.an), 16'h4);
        step_n(4); chk("t2_seg3", 16'(if_p.seg), 16'h00);
        do_load(16'h0000, 4'h0);
        wait_frame();
        step();    chk("t2_zero_seg0", 16'(if_p.seg), 16'h7E);
        step_n(4); chk("t2_zero_seg1", 16'(if_p.seg), 16'h00);

        // Two loads within one frame: last one wins
        if_p.blank_lz = 1'b0;
        wait_frame();
        do_load(16'hABCD, 4'h0);
        step();
        do_load(16'hEF01, 4'h0);
        wait_frame();
        step();    chk("t3_seg0", 16'(if_p.seg), 16'h30);
        step_n(4); chk("t3_seg1", 16'(if_p.seg), 16'h7E);
        step_n(4); chk("t3_seg2", 16'(if_p.seg), 16'h47);
        step_n(4); chk("t3_seg3", 16'(if_p.seg), 16'h4F);

        // Active-low instance on 8888
        do_load(16'h8888, 4'h5);
        wait_frame();
        step(); chk("t4_seg_n", 16'(if_n.seg), 16'h00); chk("t4_an_n", 16'(if_n.an), 16'hE);

        // Pause at idx=1 div=2, resume where it stopped
        wait_phase(6);
        if_p.enable = 1'b0;
        step_n(10);
        chk("t6_dark_an", 16'(if_p.an), 16'h0);
        if_p.enable = 1'b1;
        step(); chk("t6_an_a", 16'(if_p.an), 16'h2);
        step(); chk("t6_an_b", 16'(if_p.an), 16'h2);
        step(); chk("t6_an_c", 16'(if_p.an), 16'h4);

        // Asynchronous reset at idx=2 with data pending
        wait_phase(8);
        do_load(16'h9876, 4'hF);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t5_pending", 16'(if_p.pending), 16'h0);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        step(); chk("t5_an0", 16'(if_p.an), 16'h1); chk("t5_seg0", 16'(if_p.seg), 16'h7E);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if_p.enable   = ($urandom_range(0, 7) != 0);
            if_p.load     = ($urandom_range(0, 5) == 0);
            if_p.value    = 16'($urandom);
            if_p.dp_in    = 4'($urandom);
            if (($urandom_range(0, 15)) == 0) if_p.blank_lz = ~if_p.blank_lz;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
